// File: rtl/pc_sequencer_if.sv
// Bundle of the fetch handshake, datapath control inputs and status outputs of pc_sequencer.
// The master modport is the sequencer itself; the slave modport is the surrounding core.
interface pc_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             fetch_ready;
    logic             instr_valid;
    logic             is_b_type;
    logic             is_jal;
    logic             is_jalr;
    logic             branch_taken;
    logic [31:0]      imm;
    logic [31:0]      rs1_data;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             fetch_req;
    logic             flush;
    logic             misaligned_exc;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        input  stall, fetch_ready, instr_valid, is_b_type, is_jal, is_jalr,
               branch_taken, imm, rs1_data,
        output pc, pc_plus4, fetch_req, flush, misaligned_exc,
               retire_cnt, redirect_cnt
    );

    modport slave (
        output stall, fetch_ready, instr_valid, is_b_type, is_jal, is_jalr,
               branch_taken, imm, rs1_data,
        input  pc, pc_plus4, fetch_req, flush, misaligned_exc,
               retire_cnt, redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: IDLE -> FETCH -> EXEC loop, next-PC selection,
// misaligned-target trap, redirect flush pulse and retire/redirect counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             fetch_req_q, fetch_req_d;
    logic             flush_q, flush_d;
    logic             misaligned_q, misaligned_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    logic        accept;
    logic        redirect;
    logic        target_misaligned;
    logic [31:0] seq_target;
    logic [31:0] rel_target;
    logic [31:0] jalr_sum;
    logic [31:0] target;

    // Next-PC candidates; every add wraps modulo 2^32.
    always_comb begin
        seq_target = pc_q + 32'd4;
        rel_target = pc_q + bus.imm;
        jalr_sum   = bus.rs1_data + bus.imm;
        redirect   = bus.is_jalr | bus.is_jal | bus.branch_taken;
        if (bus.is_jalr) begin
            target = {jalr_sum[31:1], 1'b0};
        end else if (bus.is_jal || bus.branch_taken) begin
            target = rel_target;
        end else begin
            target = seq_target;
        end
        // Only bit 1 is checked: bit 0 is forced clear for JALR and even for JAL/branch immediates.
        target_misaligned = redirect & target[1];
        accept            = (state_q == S_EXEC) & ~bus.stall & bus.instr_valid;
    end

    // State register, together with the other architectural flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            fetch_req_q    <= 1'b0;
            flush_q        <= 1'b0;
            misaligned_q   <= 1'b0;
            retire_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_req_q    <= fetch_req_d;
            flush_q        <= flush_d;
            misaligned_q   <= misaligned_d;
            retire_cnt_q   <= retire_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (bus.fetch_ready) state_d = S_EXEC;
            S_EXEC: begin
                if (accept) begin
                    state_d = target_misaligned ? S_TRAP : S_FETCH;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are registered, so they follow state_d.
    always_comb begin
        pc_d           = pc_q;
        retire_cnt_d   = retire_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        flush_d        = 1'b0;
        misaligned_d   = misaligned_q;
        fetch_req_d    = (state_d == S_FETCH);
        if (accept) begin
            if (target_misaligned) begin
                misaligned_d = 1'b1;
            end else begin
                pc_d         = target;
                retire_cnt_d = retire_cnt_q + 1'b1;
                if (redirect) begin
                    redirect_cnt_d = redirect_cnt_q + 1'b1;
                    flush_d        = 1'b1;
                end
            end
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_q + 32'd4;
    assign bus.fetch_req      = fetch_req_q;
    assign bus.flush          = flush_q;
    assign bus.misaligned_exc = misaligned_q;
    assign bus.retire_cnt     = retire_cnt_q;
    assign bus.redirect_cnt   = redirect_cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table of retired instructions plus
// hand-written stall, fetch-wait, trap and asynchronous-reset sequences.
module tb_pc_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pc_sequencer_if #(.CNT_W(32)) bus ();

    pc_sequencer #(
        .RESET_PC(32'h0000_0000),
        .CNT_W   (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_b_type;
        logic        branch_taken;
        logic        is_jal;
        logic        is_jalr;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic [31:0] exp_ret;
        logic [31:0] exp_red;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_instr();
        bus.instr_valid  = 1'b0;
        bus.is_b_type    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.is_jal       = 1'b0;
        bus.is_jalr      = 1'b0;
        bus.imm          = 32'h0;
        bus.rs1_data     = 32'h0;
    endtask

    // Waits (bounded) for a fetch request, then completes the handshake so the DUT sits in EXEC.
    task automatic enter_exec(input string tag);
        int waited;
        waited = 0;
        while (bus.fetch_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.fetch_req !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_fetch_timeout: got fetch_req=%b expected 1", tag, bus.fetch_req);
        end
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        bus.fetch_ready = 1'b0;
    endtask

    task automatic do_instr(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        enter_exec(tag);
        chk({tag, "_exec_fetch_req"}, {31'b0, bus.fetch_req}, 32'd0);
        bus.is_b_type    = v.is_b_type;
        bus.branch_taken = v.branch_taken;
        bus.is_jal       = v.is_jal;
        bus.is_jalr      = v.is_jalr;
        bus.imm          = v.imm;
        bus.rs1_data     = v.rs1;
        bus.instr_valid  = 1'b1;
        @(negedge clk);
        clear_instr();
        chk({tag, "_pc"}, bus.pc, v.exp_pc);
        chk({tag, "_pc_plus4"}, bus.pc_plus4, v.exp_pc + 32'd4);
        chk({tag, "_flush"}, {31'b0, bus.flush}, {31'b0, v.exp_flush});
        chk({tag, "_retire_cnt"}, bus.retire_cnt, v.exp_ret);
        chk({tag, "_redirect_cnt"}, bus.redirect_cnt, v.exp_red);
        chk({tag, "_fetch_req"}, {31'b0, bus.fetch_req}, 32'd1);
        @(negedge clk);
        chk({tag, "_flush_end"}, {31'b0, bus.flush}, 32'd0);
        $display("vec%0d: pc=%h flush=%b retire=%0d redirect=%0d", idx, v.exp_pc, v.exp_flush,
                 v.exp_ret, v.exp_red);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        //             b    tk   jal  jalr imm           rs1           exp_pc        fl   ret  red
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0004, 1'b0, 32'd1,  32'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0008, 1'b0, 32'd2,  32'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_000C, 1'b0, 32'd3,  32'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0010, 1'b0, 32'd4,  32'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00F0, 32'h0,       32'h0000_0100, 1'b1, 32'd5,  32'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,       32'h0000_00F0, 1'b1, 32'd6,  32'd2};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,       32'h0000_0100, 1'b1, 32'd7,  32'd3};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,       32'h0000_0104, 1'b0, 32'd8,  32'd3};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h2001,    32'h0000_2004, 1'b1, 32'd9,  32'd4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h40,      32'h0000_0040, 1'b1, 32'd10, 32'd5};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h80,      32'h0000_0088, 1'b1, 32'd11, 32'd6};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1, 32'd12, 32'd7};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0000, 1'b0, 32'd13, 32'd7};

        rst_n           = 1'b0;
        bus.stall       = 1'b0;
        bus.fetch_ready = 1'b0;
        clear_instr();
        repeat (2) @(negedge clk);
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_fetch_req", {31'b0, bus.fetch_req}, 32'd0);
        chk("reset_flush", {31'b0, bus.flush}, 32'd0);
        chk("reset_misaligned", {31'b0, bus.misaligned_exc}, 32'd0);
        chk("reset_retire_cnt", bus.retire_cnt, 32'd0);
        chk("reset_redirect_cnt", bus.redirect_cnt, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_fetch_req", {31'b0, bus.fetch_req}, 32'd0);
        @(negedge clk);
        chk("idle_to_fetch", {31'b0, bus.fetch_req}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            do_instr(vecs[i], i);
        end

        // Fetch wait: fetch_ready low for 5 cycles keeps FETCH and the pc.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("fetch_wait%0d_req", i), {31'b0, bus.fetch_req}, 32'd1);
            chk($sformatf("fetch_wait%0d_pc", i), bus.pc, 32'h0);
        end
        $display("fetch_wait: 5 cycles held");
        enter_exec("stall");
        bus.stall       = 1'b1;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_pc", i), bus.pc, 32'h0);
            chk($sformatf("stall%0d_retire", i), bus.retire_cnt, 32'd13);
            chk($sformatf("stall%0d_fetch_req", i), {31'b0, bus.fetch_req}, 32'd0);
        end
        bus.stall = 1'b0;
        @(negedge clk);
        clear_instr();
        chk("stall_release_pc", bus.pc, 32'h4);
        chk("stall_release_retire", bus.retire_cnt, 32'd14);
        $display("stall: 3 cycles held, then pc=%h", bus.pc);

        // Asynchronous reset in the middle of EXEC, checked before the next rising edge.
        enter_exec("areset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_pc", bus.pc, 32'h0);
        chk("areset_retire", bus.retire_cnt, 32'd0);
        chk("areset_redirect", bus.redirect_cnt, 32'd0);
        chk("areset_fetch_req", {31'b0, bus.fetch_req}, 32'd0);
        chk("areset_flush", {31'b0, bus.flush}, 32'd0);
        $display("areset: outputs cleared mid-EXEC");
        @(negedge clk);
        rst_n = 1'b1;

        // Misaligned JALR target traps; pc holds and fetching stops.
        do_instr(vecs[0], 100);
        enter_exec("trap");
        bus.is_jalr     = 1'b1;
        bus.rs1_data    = 32'h2002;
        bus.imm         = 32'h0;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        clear_instr();
        chk("trap_pc", bus.pc, 32'h4);
        chk("trap_misaligned", {31'b0, bus.misaligned_exc}, 32'd1);
        chk("trap_flush", {31'b0, bus.flush}, 32'd0);
        chk("trap_retire", bus.retire_cnt, 32'd1);
        chk("trap_redirect", bus.redirect_cnt, 32'd0);
        bus.fetch_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("trap_hold%0d_fetch_req", i), {31'b0, bus.fetch_req}, 32'd0);
            chk($sformatf("trap_hold%0d_pc", i), bus.pc, 32'h4);
            chk($sformatf("trap_hold%0d_misaligned", i), {31'b0, bus.misaligned_exc}, 32'd1);
        end
        bus.fetch_ready = 1'b0;
        $display("trap: pc=%h misaligned=%b", bus.pc, bus.misaligned_exc);
        rst_n = 1'b0;
        #1;
        chk("trap_reset_misaligned", {31'b0, bus.misaligned_exc}, 32'd0);
        chk("trap_reset_pc", bus.pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle program-counter controller for the RV32I core. It owns the PC register, issues fetch requests to instruction memory, and selects the next PC once the datapath retires an instruction. Next-PC candidates are PC+4, the branch/JAL target and the JALR target; the branch decision comes from the branch comparator's branch_taken output. It also flags misaligned control-flow targets, pulses a flush on redirect, and keeps retire and taken-redirect counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
CNT_W, 32, width of the retire and redirect performance counters.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
stall  input  1  datapath hold; freezes the EXEC state
fetch_ready  input  1  instruction memory accepts/returns the fetch this cycle
instr_valid  input  1  datapath signals the current instruction completes this cycle
is_b_type  input  1  current instruction is a conditional branch
is_jal  input  1  current instruction is JAL
is_jalr  input  1  current instruction is JALR
branch_taken  input  1  branch comparator result, already gated by is_b_type
imm  input  32  sign-extended immediate of the current instruction
rs1_data  input  32  rs1 operand, used for JALR
pc  output  32  current PC, also the fetch address
pc_plus4  output  32  pc + 4, combinational, for the link write-back
fetch_req  output  1  fetch request to instruction memory
flush  output  1  one-cycle pulse when the PC is redirected
misaligned_exc  output  1  sticky flag: control-flow target not 4-byte aligned
retire_cnt  output  CNT_W  count of instructions accepted in EXEC
redirect_cnt  output  CNT_W  count of taken branches and jumps

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=IDLE, fetch_req=0, flush=0, misaligned_exc=0, both counters=0. Reset asserted mid-fetch or mid-EXEC aborts immediately; there is no partial update.
- States and transitions:
  - IDLE: lasts exactly one cycle after reset release, then goes to FETCH.
  - FETCH: fetch_req=1. Stays in FETCH while fetch_ready=0. On fetch_ready=1, goes to EXEC. pc does not change.
  - EXEC: fetch_req=0. If stall=1, hold everything and ignore instr_valid. If stall=0 and instr_valid=1, compute the next PC, update pc on the same clock edge, increment retire_cnt, and go to FETCH.
  - TRAP: entered from EXEC on a misaligned target. pc is held, fetch_req=0, misaligned_exc=1. Only reset leaves TRAP.
- Next-PC selection in EXEC, fixed priority: is_jalr > is_jal > branch_taken > sequential.
  - is_jalr: target = (rs1_data + imm) & 32'hFFFF_FFFE.
  - is_jal, or branch_taken=1: target = pc + imm.
  - Otherwise: pc + 4.
- is_b_type=1 with branch_taken=0 takes the sequential path and does not count as a redirect.
- All additions are 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no exception.
- Misalignment check: if target[1]=1 on a redirect, pc is not updated, the state goes to TRAP, misaligned_exc is set, retire_cnt is not incremented, and flush is not pulsed.
- A legal redirect (jalr, jal or taken branch) pulses flush=1 for exactly the cycle after the update edge and increments redirect_cnt.
- Both counters wrap silently at 2^CNT_W - 1 back to 0.
- Outputs other than pc_plus4 are registered. pc_plus4 = pc + 4, combinational.
- Inputs are sampled only in the EXEC state. The is_* signals and imm are ignored in IDLE and FETCH.
- Per-instruction latency with fetch_ready tied high: FETCH 1 cycle + EXEC 1 cycle = 2 cycles.

Test Plan:
1. Reset release with RESET_PC=0, fetch_ready=1, instr_valid=1, no branches, for 4 instructions -> pc sequence 0,4,8,C, one update every 2 cycles, retire_cnt=4, flush never asserts.
2. pc=0x100, is_b_type=1, branch_taken=1, imm=0xFFFF_FFF0 -> pc=0xF0, flush high for 1 cycle, redirect_cnt=1. Same stimulus with branch_taken=0 -> pc=0x104, no flush.
3. JALR with rs1_data=0x2001, imm=3 -> pc=0x2004 (bit 0 cleared). JALR with rs1_data=0x2002, imm=0 -> TRAP, misaligned_exc=1, pc holds, fetch_req stays 0 afterwards.
4. fetch_ready held low 5 cycles in FETCH -> fetch_req held high and pc stable. In EXEC, stall=1 for 3 cycles with instr_valid=1 -> no update, no count change.
5. is_jal=1 and is_jalr=1 together, with pc=0x40, imm=8, rs1_data=0x80 -> JALR wins, pc=0x88.
6. pc=0xFFFF_FFFC sequential retire -> pc=0. Assert rst_n=0 mid-EXEC -> pc=RESET_PC and all outputs cleared asynchronously, before the next clock edge.
